// File: rtl/link_test_if.sv
// rtl/link_test_if.sv - link test controller handshake/status bundle
// Ports (slave view = controller):
//   in : start, abort, data_tx, data_rx
//   out: link_rst, busy, locked, done, fail, delay_o, err_count, bit_count, state_o
interface link_test_if #(
    parameter int CNT_W = 16
);
    logic             start;
    logic             abort;
    logic             data_tx;
    logic             data_rx;
    logic             link_rst;
    logic             busy;
    logic             locked;
    logic             done;
    logic             fail;
    logic [3:0]       delay_o;
    logic [CNT_W-1:0] err_count;
    logic [CNT_W-1:0] bit_count;
    logic [2:0]       state_o;

    modport master (
        output start, abort, data_tx, data_rx,
        input  link_rst, busy, locked, done, fail, delay_o, err_count, bit_count, state_o
    );

    modport slave (
        input  start, abort, data_tx, data_rx,
        output link_rst, busy, locked, done, fail, delay_o, err_count, bit_count, state_o
    );
endinterface

// File: rtl/link_test_controller.sv
// rtl/link_test_controller.sv - link BER test sequencer (reset, settle, delay search, measure)
// Ports:
//   clk : data clock, rising edge
//   rst : asynchronous active-low reset
//   lnk : link_test_if.slave (control inputs, tx/rx bits, status/count outputs)
module link_test_controller #(
    parameter int RST_CYCLES    = 4,
    parameter int SETTLE_CYCLES = 16,
    parameter int MAX_DELAY     = 15,
    parameter int SYNC_LEN      = 32,
    parameter int WINDOW        = 1000,
    parameter int CNT_W         = 16
) (
    input logic      clk,
    input logic      rst,
    link_test_if.slave lnk
);
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        RESET_LINK = 3'd1,
        SETTLE     = 3'd2,
        ALIGN      = 3'd3,
        MEASURE    = 3'd4,
        DONE       = 3'd5,
        FAIL       = 3'd6
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        phase_q, phase_d;
    logic [3:0]         delay_q, delay_d;
    logic               flag_q, flag_d;
    logic [CNT_W-1:0]   err_q, err_d;
    logic [CNT_W-1:0]   bit_q, bit_d;
    logic               link_rst_q;
    logic [MAX_DELAY:1] tx_dly_q;
    logic [MAX_DELAY:0] taps;
    logic               mismatch;

    // taps[k] is data_tx delayed k cycles; tap 0 is the live input
    assign taps     = {tx_dly_q, lnk.data_tx};
    assign mismatch = lnk.data_rx ^ taps[delay_q];

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        delay_d = delay_q;
        flag_d  = flag_q;
        err_d   = err_q;
        bit_d   = bit_q;
        case (state_q)
            IDLE, DONE, FAIL: begin
                if (lnk.start) begin
                    state_d = RESET_LINK;
                    phase_d = 32'(RST_CYCLES - 1);
                    delay_d = 4'd0;
                    flag_d  = 1'b0;
                    err_d   = '0;
                    bit_d   = '0;
                end
            end
            RESET_LINK: begin
                if (phase_q == 32'd0) begin
                    state_d = SETTLE;
                    phase_d = 32'(SETTLE_CYCLES - 1);
                end else begin
                    phase_d = phase_q - 32'd1;
                end
            end
            SETTLE: begin
                if (phase_q == 32'd0) begin
                    state_d = ALIGN;
                    phase_d = 32'(SYNC_LEN - 1);
                    delay_d = 4'd0;
                    flag_d  = 1'b0;
                end else begin
                    phase_d = phase_q - 32'd1;
                end
            end
            ALIGN: begin
                if (phase_q == 32'd0) begin
                    // last cycle of this candidate: its own mismatch still counts
                    if (!(flag_q || mismatch)) begin
                        state_d = MEASURE;
                        phase_d = 32'(WINDOW - 1);
                    end else if (delay_q < 4'(MAX_DELAY)) begin
                        delay_d = delay_q + 4'd1;
                        flag_d  = 1'b0;
                        phase_d = 32'(SYNC_LEN - 1);
                    end else begin
                        state_d = FAIL;
                    end
                end else begin
                    phase_d = phase_q - 32'd1;
                    flag_d  = flag_q | mismatch;
                end
            end
            MEASURE: begin
                bit_d = bit_q + 1'b1;
                if (mismatch && (err_q != {CNT_W{1'b1}})) begin
                    err_d = err_q + 1'b1;
                end
                // window length is tracked by phase so a narrow bit_count may wrap
                if (phase_q == 32'd0) begin
                    state_d = DONE;
                end else begin
                    phase_d = phase_q - 32'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        // abort freezes all results for inspection and wins over start
        if (lnk.abort) begin
            state_d = IDLE;
            phase_d = phase_q;
            delay_d = delay_q;
            flag_d  = flag_q;
            err_d   = err_q;
            bit_d   = bit_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            phase_q    <= 32'd0;
            delay_q    <= 4'd0;
            flag_q     <= 1'b0;
            err_q      <= '0;
            bit_q      <= '0;
            link_rst_q <= 1'b0;
            tx_dly_q   <= '0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            delay_q    <= delay_d;
            flag_q     <= flag_d;
            err_q      <= err_d;
            bit_q      <= bit_d;
            link_rst_q <= (state_d == RESET_LINK);
            tx_dly_q   <= taps[MAX_DELAY-1:0];
        end
    end

    assign lnk.link_rst  = link_rst_q;
    assign lnk.busy      = (state_q == RESET_LINK) || (state_q == SETTLE) ||
                           (state_q == ALIGN) || (state_q == MEASURE);
    assign lnk.locked    = (state_q == MEASURE) || (state_q == DONE);
    assign lnk.done      = (state_q == DONE);
    assign lnk.fail      = (state_q == FAIL);
    assign lnk.delay_o   = delay_q;
    assign lnk.err_count = err_q;
    assign lnk.bit_count = bit_q;
    assign lnk.state_o   = state_q;
endmodule

// File: tb/tb_link_test_controller.sv
// tb/tb_link_test_controller.sv - directed self-checking bench for link_test_controller
module tb_link_test_controller;
    logic clk;
    logic rst;

    link_test_if #(.CNT_W(16)) lk ();
    link_test_if #(.CNT_W(4))  lk2 ();

    link_test_controller u_dut (
        .clk (clk),
        .rst (rst),
        .lnk (lk)
    );

    link_test_controller #(.CNT_W(4), .WINDOW(40)) u_sat (
        .clk (clk),
        .rst (rst),
        .lnk (lk2)
    );

    int          n_cmp;
    int          n_err;
    int          cyc;
    logic [6:0]  lfsr;
    logic [15:0] hist;
    logic        rx_stuck;
    logic        en_flip;
    logic        flip;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // one data-clock cycle: inputs for the new cycle are applied 1 time unit after the edge
    task automatic step();
        logic fb;
        @(posedge clk);
        #1;
        cyc++;
        fb   = lfsr[6] ^ lfsr[5];
        lfsr = {lfsr[5:0], fb};
        hist = {hist[14:0], lfsr[0]};
        flip = en_flip && (cyc >= 200) && (cyc <= 600) && ((cyc % 100) == 0);
        lk.data_tx  = hist[0];
        lk2.data_tx = hist[0];
        lk.data_rx  = rx_stuck ? 1'b0 : (hist[3] ^ flip);
        lk2.data_rx = lk2.locked ? ~hist[3] : hist[3];
    endtask

    task automatic run_to(input int n);
        while (cyc < n) step();
    endtask

    task automatic start_run(input logic both);
        lk.start = 1'b1;
        if (both) lk2.start = 1'b1;
        cyc = 0;
        step();
        lk.start  = 1'b0;
        lk2.start = 1'b0;
    endtask

    initial begin
        n_cmp = 0; n_err = 0; cyc = 0;
        lfsr = 7'h7F; hist = '0;
        rx_stuck = 1'b0; en_flip = 1'b0; flip = 1'b0;
        rst = 1'b0;
        lk.start = 1'b0;  lk.abort = 1'b0;  lk.data_tx = 1'b0;  lk.data_rx = 1'b0;
        lk2.start = 1'b0; lk2.abort = 1'b0; lk2.data_tx = 1'b0; lk2.data_rx = 1'b0;

        // reset state
        step(); step();
        chk("rst_state", lk.state_o, 0);
        chk("rst_link_rst", lk.link_rst, 0);
        chk("rst_busy", lk.busy, 0);
        chk("rst_counts", {lk.err_count, lk.bit_count}, 0);
        chk("rst_delay", lk.delay_o, 0);
        rst = 1'b1;
        for (int i = 0; i < 20; i++) step();

        // start together with abort: abort wins
        lk.start = 1'b1; lk.abort = 1'b1;
        step();
        lk.start = 1'b0; lk.abort = 1'b0;
        chk("abort_vs_start_state", lk.state_o, 0);
        chk("abort_vs_start_link_rst", lk.link_rst, 0);

        // scenario 1: rx = tx delayed 3
        start_run(1'b1);
        chk("s1_c1_state", lk.state_o, 1);
        chk("s1_c1_link_rst", lk.link_rst, 1);
        chk("s1_c1_busy", lk.busy, 1);
        run_to(4);
        chk("s1_c4_state", lk.state_o, 1);
        chk("s1_c4_link_rst", lk.link_rst, 1);
        run_to(5);
        chk("s1_c5_state", lk.state_o, 2);
        chk("s1_c5_link_rst", lk.link_rst, 0);
        run_to(20);
        chk("s1_c20_state", lk.state_o, 2);
        run_to(21);
        chk("s1_c21_state", lk.state_o, 3);
        chk("s1_c21_delay", lk.delay_o, 0);
        run_to(148);
        chk("s1_c148_state", lk.state_o, 3);
        chk("s1_c148_delay", lk.delay_o, 3);
        run_to(149);
        chk("s1_c149_state", lk.state_o, 4);
        chk("s1_c149_delay", lk.delay_o, 3);
        chk("s1_c149_locked", lk.locked, 1);
        chk("sat_c149_state", lk2.state_o, 4);
        run_to(189);
        chk("sat_c189_state", lk2.state_o, 5);
        chk("sat_err_saturated", lk2.err_count, 15);
        chk("sat_bit_wrapped", lk2.bit_count, 8);
        run_to(1148);
        chk("s1_c1148_state", lk.state_o, 4);
        chk("s1_c1148_bits", lk.bit_count, 999);
        run_to(1149);
        chk("s1_done_state", lk.state_o, 5);
        chk("s1_done_flag", lk.done, 1);
        chk("s1_done_bits", lk.bit_count, 1000);
        chk("s1_done_errs", lk.err_count, 0);
        chk("s1_done_busy", lk.busy, 0);
        chk("s1_done_locked", lk.locked, 1);
        step(); step();
        chk("s1_done_hold_bits", lk.bit_count, 1000);

        // scenario 2: five single-bit flips during MEASURE
        en_flip = 1'b1;
        start_run(1'b0);
        chk("s2_restart_bits_cleared", lk.bit_count, 0);
        chk("s2_restart_state", lk.state_o, 1);
        run_to(1149);
        chk("s2_done_state", lk.state_o, 5);
        chk("s2_errs", lk.err_count, 5);
        chk("s2_bits", lk.bit_count, 1000);
        en_flip = 1'b0;

        // scenario 3: rx stuck at 0, every candidate fails
        rx_stuck = 1'b1;
        start_run(1'b0);
        run_to(53);
        chk("s3_c53_delay", lk.delay_o, 1);
        run_to(532);
        chk("s3_c532_state", lk.state_o, 3);
        chk("s3_c532_delay", lk.delay_o, 15);
        run_to(533);
        chk("s3_fail_state", lk.state_o, 6);
        chk("s3_fail_flag", lk.fail, 1);
        chk("s3_fail_delay", lk.delay_o, 15);
        chk("s3_fail_locked", lk.locked, 0);
        chk("s3_fail_busy", lk.busy, 0);
        rx_stuck = 1'b0;

        // scenario 4: abort 100 cycles into MEASURE
        start_run(1'b0);
        run_to(249);
        chk("s4_pre_abort_bits", lk.bit_count, 100);
        lk.abort = 1'b1;
        step();
        lk.abort = 1'b0;
        chk("s4_abort_state", lk.state_o, 0);
        chk("s4_abort_busy", lk.busy, 0);
        chk("s4_abort_link_rst", lk.link_rst, 0);
        chk("s4_abort_bits", lk.bit_count, 100);
        chk("s4_abort_delay", lk.delay_o, 3);
        step(); step();
        chk("s4_hold_bits", lk.bit_count, 100);
        start_run(1'b0);
        chk("s4_restart_link_rst", lk.link_rst, 1);
        chk("s4_restart_bits", lk.bit_count, 0);
        chk("s4_restart_delay", lk.delay_o, 0);

        // scenario 5: asynchronous reset mid-ALIGN
        run_to(60);
        chk("s5_pre_state", lk.state_o, 3);
        #2;
        rst = 1'b0;
        #1;
        chk("s5_async_state", lk.state_o, 0);
        chk("s5_async_busy", lk.busy, 0);
        chk("s5_async_link_rst", lk.link_rst, 0);
        chk("s5_async_delay", lk.delay_o, 0);
        chk("s5_async_locked", lk.locked, 0);
        step();
        rst = 1'b1;
        step(); step();
        start_run(1'b0);
        chk("s5_c1_link_rst", lk.link_rst, 1);
        run_to(149);
        chk("s5_c149_state", lk.state_o, 4);
        chk("s5_c149_delay", lk.delay_o, 3);
        run_to(1149);
        chk("s5_done_state", lk.state_o, 5);
        chk("s5_done_bits", lk.bit_count, 1000);
        chk("s5_done_errs", lk.err_count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
